ps2_key_ctrl: RTL and testbench

//  Sequences raw PS/2 scan-code bytes from the keyboard receiver into key events. Decodes E0 (extended)
//  and F0 (break) prefixes, tracks the currently held key, suppresses typematic repeats and counts presses.

---
 rtl/ps2_key_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_ps2_key_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl
//   Turns raw PS/2 set-2 scan-code bytes from the byte receiver into key events.
//   The block strips the E0 (extended) and F0 (break) prefixes and tracks the key
//   that is currently held. Typematic repeats are passed through as make events
//   but are not counted. Both sides use valid/ready handshakes.
//
// Parameters
//   TIMEOUT_CYC : idle cycles allowed after a prefix byte before the sequence is aborted
//   CNT_W       : width of the press counter (wraps modulo 2**CNT_W)
//
// Ports
//   clk, resetn        : clock, synchronous active-low reset
//   in_valid/in_ready  : receiver byte handshake; in_ready = ~ev_valid
//   in_data            : scan-code byte
//   ev_valid/ev_ready  : event handshake; the event is held until it is accepted
//   ev_code            : event scan code with prefixes stripped
//   ev_ext / ev_break  : the event carried E0 / the event is a release
//   held, held_code    : a key is down, and its code
//   press_cnt          : number of new key presses since reset
//   timeout_err        : sticky flag, set when a prefix sequence times out
//   ev_ascii           : only when KEY_ASCII_EN is defined; ASCII of ev_code
//                        (lower-case letters, digits, space), 0x00 otherwise
//
// Build option: define KEY_ASCII_EN to add the ev_ascii port and the lookup ROM.
module ps2_key_ctrl #(
  parameter logic [19:0] TIMEOUT_CYC = 20'd1000000,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_break,
  output logic             held,
  output logic [7:0]       held_code,
  output logic [CNT_W-1:0] press_cnt,
  output logic             timeout_err
`ifdef KEY_ASCII_EN
  ,
  output logic [7:0]       ev_ascii
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } state_t;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [19:0]      r_timer;
  logic             r_ev_valid;
  logic [7:0]       r_ev_code;
  logic             r_ev_ext;
  logic             r_ev_break;
  logic             r_held;
  logic             r_held_ext;
  logic [7:0]       r_held_code;
  logic [CNT_W-1:0] r_press_cnt;
  logic             r_timeout_err;

  logic w_accept;
  logic w_expire;
  logic w_emit;
  logic w_emit_ext;
  logic w_emit_brk;
  logic w_timeout;
  logic w_match;

  assign w_accept = in_valid & ~r_ev_valid;
  // Backpressure freezes the timeout so a stalled consumer never aborts a sequence.
  assign w_expire = ~r_ev_valid & (r_timer == (TIMEOUT_CYC - 20'd1));
  assign w_match  = r_held & (r_held_ext == w_emit_ext) & (r_held_code == in_data);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // An accepted byte always takes priority over the timeout in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_emit_ext  = 1'b0;
    w_emit_brk  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (in_data == PFX_EXT) begin
            w_state_nxt = S_EXT;
          end else if (in_data == PFX_BRK) begin
            w_state_nxt = S_BRK;
          end else begin
            w_emit = 1'b1;
          end
        end
      end
      S_EXT: begin
        if (w_accept) begin
          if (in_data == PFX_BRK) begin
            w_state_nxt = S_EXT_BRK;
          end else if (in_data != PFX_EXT) begin
            w_emit      = 1'b1;
            w_emit_ext  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else if (w_expire) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_BRK: begin
        if (w_accept) begin
          w_emit      = 1'b1;
          w_emit_brk  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_expire) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_EXT_BRK: begin
        if (w_accept) begin
          w_emit      = 1'b1;
          w_emit_ext  = 1'b1;
          w_emit_brk  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_expire) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_timer <= '0;
    end else if (w_accept || (w_state_nxt == S_IDLE)) begin
      r_timer <= '0;
    end else if (!r_ev_valid) begin
      r_timer <= r_timer + 20'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ev_valid    <= 1'b0;
      r_ev_code     <= '0;
      r_ev_ext      <= 1'b0;
      r_ev_break    <= 1'b0;
      r_held        <= 1'b0;
      r_held_ext    <= 1'b0;
      r_held_code   <= '0;
      r_press_cnt   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_ev_valid && ev_ready) begin
        r_ev_valid <= 1'b0;
      end
      // w_emit needs an accepted byte, so it never coincides with a pending event.
      if (w_emit) begin
        r_ev_valid <= 1'b1;
        r_ev_code  <= in_data;
        r_ev_ext   <= w_emit_ext;
        r_ev_break <= w_emit_brk;
        if (w_emit_brk) begin
          if (w_match) begin
            r_held <= 1'b0;
          end
        end else if (!w_match) begin
          r_held      <= 1'b1;
          r_held_ext  <= w_emit_ext;
          r_held_code <= in_data;
          r_press_cnt <= r_press_cnt + CNT_W'(1);
        end
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign in_ready    = ~r_ev_valid;
  assign ev_valid    = r_ev_valid;
  assign ev_code     = r_ev_code;
  assign ev_ext      = r_ev_ext;
  assign ev_break    = r_ev_break;
  assign held        = r_held;
  assign held_code   = r_held_code;
  assign press_cnt   = r_press_cnt;
  assign timeout_err = r_timeout_err;

`ifdef KEY_ASCII_EN
  logic [7:0] w_ascii;

  always_comb begin
    w_ascii = 8'h00;
    if (!r_ev_ext) begin
      case (r_ev_code)
        8'h1C: w_ascii = 8'h61;  8'h32: w_ascii = 8'h62;  8'h21: w_ascii = 8'h63;
        8'h23: w_ascii = 8'h64;  8'h24: w_ascii = 8'h65;  8'h2B: w_ascii = 8'h66;
        8'h34: w_ascii = 8'h67;  8'h33: w_ascii = 8'h68;  8'h43: w_ascii = 8'h69;
        8'h3B: w_ascii = 8'h6A;  8'h42: w_ascii = 8'h6B;  8'h4B: w_ascii = 8'h6C;
        8'h3A: w_ascii = 8'h6D;  8'h31: w_ascii = 8'h6E;  8'h44: w_ascii = 8'h6F;
        8'h4D: w_ascii = 8'h70;  8'h15: w_ascii = 8'h71;  8'h2D: w_ascii = 8'h72;
        8'h1B: w_ascii = 8'h73;  8'h2C: w_ascii = 8'h74;  8'h3C: w_ascii = 8'h75;
        8'h2A: w_ascii = 8'h76;  8'h1D: w_ascii = 8'h77;  8'h22: w_ascii = 8'h78;
        8'h35: w_ascii = 8'h79;  8'h1A: w_ascii = 8'h7A;
        8'h45: w_ascii = 8'h30;  8'h16: w_ascii = 8'h31;  8'h1E: w_ascii = 8'h32;
        8'h26: w_ascii = 8'h33;  8'h25: w_ascii = 8'h34;  8'h2E: w_ascii = 8'h35;
        8'h36: w_ascii = 8'h36;  8'h3D: w_ascii = 8'h37;  8'h3E: w_ascii = 8'h38;
        8'h46: w_ascii = 8'h39;
        8'h29: w_ascii = 8'h20;
        default: w_ascii = 8'h00;
      endcase
    end
  end

  assign ev_ascii = w_ascii;
`endif

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Testbench for ps2_key_ctrl: directed scenarios followed by a randomized byte stream.
// The expected events come from a byte-sequence parser model, and are compared
// while each event is pending and again when it is accepted.
module tb_ps2_key_ctrl;

  localparam logic [19:0] TMO = 20'd16;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       ev_valid;
  logic       ev_ready = 1'b0;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic       held;
  logic [7:0] held_code;
  logic [7:0] press_cnt;
  logic       timeout_err;
`ifdef KEY_ASCII_EN
  logic [7:0] ev_ascii;
`endif

  always #5 clk = ~clk;

  ps2_key_ctrl #(.TIMEOUT_CYC(TMO), .CNT_W(8)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_code(ev_code), .ev_ext(ev_ext), .ev_break(ev_break),
    .held(held), .held_code(held_code), .press_cnt(press_cnt),
    .timeout_err(timeout_err)
`ifdef KEY_ASCII_EN
    , .ev_ascii(ev_ascii)
`endif
  );

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       hld;
    logic [7:0] hcode;
    logic [7:0] cnt;
    logic       err;
  } ev_t;

  ev_t exp_q[$];

  // Reference model state: pending prefixes, held key, press count, sticky error.
  logic       m_pext, m_pbrk, m_held, m_hext, m_err;
  logic [7:0] m_hcode, m_cnt;

  int n_chk = 0;
  int n_pass = 0;
  int rdy_mode = 1;  // 0 random, 1 always ready, 2 never ready

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    m_pext = 0; m_pbrk = 0; m_held = 0; m_hext = 0; m_err = 0;
    m_hcode = 0; m_cnt = 0;
    exp_q.delete();
  endtask

  task automatic model_emit(input logic [7:0] b, input logic x, input logic br);
    ev_t e;
    logic same;
    same = m_held && (m_hext == x) && (m_hcode == b);
    m_pext = 0;
    m_pbrk = 0;
    if (br) begin
      if (same) m_held = 0;
    end else if (!same) begin
      m_held = 1; m_hext = x; m_hcode = b; m_cnt = m_cnt + 8'd1;
    end
    e.code = b; e.ext = x; e.brk = br; e.hld = m_held;
    e.hcode = m_hcode; e.cnt = m_cnt; e.err = m_err;
    exp_q.push_back(e);
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_pbrk) model_emit(b, m_pext, 1'b1);
    else if (b == 8'hE0) m_pext = 1;
    else if (b == 8'hF0) m_pbrk = 1;
    else model_emit(b, m_pext, 1'b0);
  endtask

  task automatic model_gap(input int g);
    if ((m_pext || m_pbrk) && g >= int'(TMO)) begin
      m_pext = 0; m_pbrk = 0; m_err = 1;
    end
  endtask

  // Called at a negedge; returns at a negedge after g idle cycles.
  task automatic send(input logic [7:0] b, input int g);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("byte_accept_wait", 32'd0, 32'd1);
    else model_byte(b);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (g) @(negedge clk);
    model_gap(g);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn   = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ev_valid", ev_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_held", held, 0);
    chk("rst_press_cnt", press_cnt, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_ev_code", ev_code, 0);
    model_clear();
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || ev_valid) && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk("drain_queue", exp_q.size(), 0);
  endtask

  // Event monitor: chooses ev_ready, then checks any pending event against the model.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       ev_ready = ($urandom_range(0, 3) != 0);
        1:       ev_ready = 1'b1;
        default: ev_ready = 1'b0;
      endcase
      if (resetn && ev_valid) begin
        if (exp_q.size() == 0) begin
          chk("ev_unexpected", {24'd0, ev_code}, 32'hFFFF);
        end else begin
          e = exp_q[0];
          chk("ev_code", ev_code, e.code);
          chk("ev_ext", ev_ext, e.ext);
          chk("ev_break", ev_break, e.brk);
          if (ev_ready) begin
            chk("held", held, e.hld);
            if (e.hld) chk("held_code", held_code, e.hcode);
            chk("press_cnt", press_cnt, e.cnt);
            chk("timeout_err", timeout_err, e.err);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [7:0] b;
    logic [7:0] pool [6];
    pool[0] = 8'h1C; pool[1] = 8'h32; pool[2] = 8'h21;
    pool[3] = 8'h23; pool[4] = 8'h75; pool[5] = 8'h6B;
    model_clear();

    // Make then break of one key.
    do_reset();
    rdy_mode = 1;
    send(8'h1C, 0); send(8'hF0, 0); send(8'h1C, 0);
    drain();
    chk("t1_cnt", press_cnt, 1);
    chk("t1_held", held, 0);

    // Extended make/break.
    do_reset();
    send(8'hE0, 0); send(8'h75, 0); send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 0);
    drain();
    chk("t2_cnt", press_cnt, 1);

    // Typematic repeats.
    do_reset();
    send(8'h1C, 0); send(8'h1C, 1); send(8'h1C, 0);
    drain();
    chk("t3_held", held, 1);
    chk("t3_held_code", held_code, 8'h1C);
    send(8'hF0, 0); send(8'h1C, 0);
    drain();
    chk("t3_cnt", press_cnt, 1);
    chk("t3_held_end", held, 0);

    // Backpressure: a waiting byte is not taken while an event is pending.
    do_reset();
    rdy_mode = 2;
    send(8'h1C, 0);
    in_valid = 1'b1;
    in_data  = 8'h32;
    repeat (4) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_ev_valid", ev_valid, 1);
      chk("bp_ev_code", ev_code, 8'h1C);
`ifdef KEY_ASCII_EN
      chk("bp_ev_ascii", ev_ascii, 8'h61);
`endif
    end
    rdy_mode = 1;
    send(8'h32, 0);
    drain();
    chk("bp_held_code", held_code, 8'h32);
    chk("bp_cnt", press_cnt, 2);

    // Timeout after a prefix, then recovery.
    do_reset();
    send(8'hE0, 16);
    chk("tmo_err", timeout_err, 1);
    chk("tmo_no_event", ev_valid, 0);
    send(8'h29, 0);
    drain();
    chk("tmo_cnt", press_cnt, 1);

    // One cycle short of the timeout: the byte wins.
    do_reset();
    send(8'hE0, 15); send(8'h75, 0);
    drain();
    chk("tmo_edge_err", timeout_err, 0);
    chk("tmo_edge_cnt", press_cnt, 1);

    // Counter wrap.
    do_reset();
    for (int unsigned i = 0; i < 255; i++) send((i % 2 == 0) ? 8'h15 : 8'h16, 0);
    drain();
    chk("wrap_ff", press_cnt, 8'hFF);
    send(8'h2A, 0);
    drain();
    chk("wrap_00", press_cnt, 8'h00);

    // Reset while an event is pending.
    do_reset();
    rdy_mode = 2;
    send(8'h1C, 0);
    chk("pend_ev_valid", ev_valid, 1);
    do_reset();

    // Randomized stream with random backpressure.
    rdy_mode = 0;
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      if (r < 15) b = 8'hE0;
      else if (r < 28) b = 8'hF0;
      else b = pool[$urandom_range(0, 5)];
      r = $urandom_range(0, 99);
      send(b, (r < 8) ? $urandom_range(14, 17) : $urandom_range(0, 2));
    end
    rdy_mode = 1;
    drain();
    repeat (20) @(negedge clk);
    chk("rand_cnt", press_cnt, m_cnt);
    chk("rand_held", held, m_held);
    chk("rand_err", timeout_err, m_err);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
